// File: rtl/alu_exec_unit.sv
// Execute-stage ALU with a HI/LO multiply unit and an iterative divider.
// Single-cycle ops return in one cycle; divides hold in_ready low until done.
module alu_exec_unit #(
  parameter int DW        = 32,
  parameter int DIV_ITERS = 32
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [4:0]    aluctrl,
  input  logic [DW-1:0] src_a,
  input  logic [DW-1:0] src_b,
  input  logic [4:0]    sa,
  output logic          out_valid,
  output logic [DW-1:0] result,
  output logic          overflow,
  output logic          zero,
  output logic [DW-1:0] hi,
  output logic [DW-1:0] lo
);

  localparam logic [4:0] OP_ADD   = 5'd0;
  localparam logic [4:0] OP_SUB   = 5'd1;
  localparam logic [4:0] OP_AND   = 5'd2;
  localparam logic [4:0] OP_OR    = 5'd3;
  localparam logic [4:0] OP_XOR   = 5'd4;
  localparam logic [4:0] OP_NOR   = 5'd5;
  localparam logic [4:0] OP_SLT   = 5'd6;
  localparam logic [4:0] OP_SLL   = 5'd7;
  localparam logic [4:0] OP_SRL   = 5'd8;
  localparam logic [4:0] OP_SRA   = 5'd9;
  localparam logic [4:0] OP_SLLV  = 5'd10;
  localparam logic [4:0] OP_SRLV  = 5'd11;
  localparam logic [4:0] OP_SRAV  = 5'd12;
  localparam logic [4:0] OP_MULT  = 5'd13;
  localparam logic [4:0] OP_MULTU = 5'd14;
  localparam logic [4:0] OP_DIV   = 5'd15;
  localparam logic [4:0] OP_DIVU  = 5'd16;

  localparam int CW = $clog2(DIV_ITERS);
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV_ITERS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DIV_RUN,
    S_DIV_DONE
  } state_e;

  state_e state_q, state_d;

  logic          out_valid_q, out_valid_d;
  logic [DW-1:0] result_q, result_d;
  logic          overflow_q, overflow_d;
  logic          zero_q, zero_d;
  logic [DW-1:0] hi_q, hi_d;
  logic [DW-1:0] lo_q, lo_d;

  logic [DW-1:0] rem_q, rem_d;
  logic [DW-1:0] quo_q, quo_d;
  logic [DW-1:0] dvs_q, dvs_d;
  logic [DW-1:0] dnd_q, dnd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          negq_q, negq_d;
  logic          negr_q, negr_d;
  logic          dz_q, dz_d;

  logic          accept;
  logic [DW-1:0] add_sum, sub_dif;
  logic [DW-1:0] alu_res;
  logic          alu_ovf;
  logic [2*DW-1:0] mul_s, mul_u;
  logic [DW:0]   rem_sh, trial;
  logic          is_sdiv;
  logic [DW-1:0] a_mag, b_mag;
  logic [DW-1:0] q_fin, r_fin;

  assign in_ready  = (state_q == S_IDLE);
  assign accept    = in_valid & in_ready & ~flush;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign overflow  = overflow_q;
  assign zero      = zero_q;
  assign hi        = hi_q;
  assign lo        = lo_q;

  // Single-cycle ALU result and signed-overflow detection
  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    add_sum = src_a + src_b;
    sub_dif = src_a - src_b;
    case (aluctrl)
      OP_ADD: begin
        alu_res = add_sum;
        alu_ovf = (src_a[DW-1] == src_b[DW-1]) &&
                  (add_sum[DW-1] != src_a[DW-1]);
      end
      OP_SUB: begin
        alu_res = sub_dif;
        alu_ovf = (src_a[DW-1] != src_b[DW-1]) &&
                  (sub_dif[DW-1] != src_a[DW-1]);
      end
      OP_AND:  alu_res = src_a & src_b;
      OP_OR:   alu_res = src_a | src_b;
      OP_XOR:  alu_res = src_a ^ src_b;
      OP_NOR:  alu_res = ~(src_a | src_b);
      OP_SLT:  alu_res = {{(DW-1){1'b0}},
                          ($signed(src_a) < $signed(src_b))};
      OP_SLL:  alu_res = src_b << sa;
      OP_SRL:  alu_res = src_b >> sa;
      OP_SRA:  alu_res = $signed(src_b) >>> sa;
      OP_SLLV: alu_res = src_b << src_a[4:0];
      OP_SRLV: alu_res = src_b >> src_a[4:0];
      OP_SRAV: alu_res = $signed(src_b) >>> src_a[4:0];
      default: alu_res = '0;
    endcase
  end

  // Products, divider step and final sign fix-up
  always_comb begin
    mul_s   = $signed({{DW{src_a[DW-1]}}, src_a}) *
              $signed({{DW{src_b[DW-1]}}, src_b});
    mul_u   = {{DW{1'b0}}, src_a} * {{DW{1'b0}}, src_b};
    is_sdiv = (aluctrl == OP_DIV);
    a_mag   = (is_sdiv && src_a[DW-1]) ? -src_a : src_a;
    b_mag   = (is_sdiv && src_b[DW-1]) ? -src_b : src_b;
    rem_sh  = {rem_q, quo_q[DW-1]};
    trial   = rem_sh - {1'b0, dvs_q};
    q_fin   = negq_q ? -quo_q : quo_q;
    r_fin   = negr_q ? -rem_q : rem_q;
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    out_valid_d = 1'b0;
    result_d    = result_q;
    overflow_d  = overflow_q;
    zero_d      = zero_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dvs_d       = dvs_q;
    dnd_d       = dnd_q;
    cnt_d       = cnt_q;
    negq_d      = negq_q;
    negr_d      = negr_q;
    dz_d        = dz_q;
    if (flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            if (aluctrl == OP_DIV || aluctrl == OP_DIVU) begin
              state_d = S_DIV_RUN;
              rem_d   = '0;
              quo_d   = a_mag;
              dvs_d   = b_mag;
              dnd_d   = src_a;
              cnt_d   = '0;
              negq_d  = is_sdiv & (src_a[DW-1] ^ src_b[DW-1]);
              negr_d  = is_sdiv & src_a[DW-1];
              dz_d    = (src_b == '0);
            end else if (aluctrl == OP_MULT ||
                         aluctrl == OP_MULTU) begin
              out_valid_d = 1'b1;
              overflow_d  = 1'b0;
              if (aluctrl == OP_MULT) begin
                {hi_d, lo_d} = mul_s;
              end else begin
                {hi_d, lo_d} = mul_u;
              end
              result_d = lo_d;
              zero_d   = (lo_d == '0);
            end else begin
              out_valid_d = 1'b1;
              result_d    = alu_res;
              overflow_d  = alu_ovf;
              zero_d      = (alu_res == '0);
            end
          end
        end
        S_DIV_RUN: begin
          if (!trial[DW]) begin
            rem_d = trial[DW-1:0];
            quo_d = {quo_q[DW-2:0], 1'b1};
          end else begin
            rem_d = rem_sh[DW-1:0];
            quo_d = {quo_q[DW-2:0], 1'b0};
          end
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CNT_LAST) begin
            state_d = S_DIV_DONE;
          end
        end
        S_DIV_DONE: begin
          state_d     = S_IDLE;
          out_valid_d = 1'b1;
          overflow_d  = 1'b0;
          if (dz_q) begin
            lo_d = '1;
            hi_d = dnd_q;
          end else begin
            lo_d = q_fin;
            hi_d = r_fin;
          end
          result_d = lo_d;
          zero_d   = (lo_d == '0);
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      overflow_q  <= 1'b0;
      zero_q      <= 1'b0;
      hi_q        <= '0;
      lo_q        <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvs_q       <= '0;
      dnd_q       <= '0;
      cnt_q       <= '0;
      negq_q      <= 1'b0;
      negr_q      <= 1'b0;
      dz_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      overflow_q  <= overflow_d;
      zero_q      <= zero_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dvs_q       <= dvs_d;
      dnd_q       <= dnd_d;
      cnt_q       <= cnt_d;
      negq_q      <= negq_d;
      negr_q      <= negr_d;
      dz_q        <= dz_d;
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit: ALU ops, HI/LO multiply,
// iterative divide latency and special cases, flush and reset aborts.
module tb_alu_exec_unit;

  localparam logic [4:0] OP_ADD   = 5'd0;
  localparam logic [4:0] OP_SUB   = 5'd1;
  localparam logic [4:0] OP_NOR   = 5'd5;
  localparam logic [4:0] OP_SLT   = 5'd6;
  localparam logic [4:0] OP_SRA   = 5'd9;
  localparam logic [4:0] OP_SRAV  = 5'd12;
  localparam logic [4:0] OP_MULT  = 5'd13;
  localparam logic [4:0] OP_MULTU = 5'd14;
  localparam logic [4:0] OP_DIV   = 5'd15;
  localparam logic [4:0] OP_DIVU  = 5'd16;
  localparam logic [4:0] OP_BAD   = 5'd31;

  logic        clk;
  logic        resetn;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  aluctrl;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic [4:0]  sa;
  logic        out_valid;
  logic [31:0] result;
  logic        overflow;
  logic        zero;
  logic [31:0] hi;
  logic [31:0] lo;

  int total;
  int passed;
  int cyc;
  int busy;
  int pulses;

  alu_exec_unit #(.DW(32), .DIV_ITERS(32)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .aluctrl   (aluctrl),
    .src_a     (src_a),
    .src_b     (src_b),
    .sa        (sa),
    .out_valid (out_valid),
    .result    (result),
    .overflow  (overflow),
    .zero      (zero),
    .hi        (hi),
    .lo        (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic issue(input logic [4:0] op,
                       input logic [31:0] a,
                       input logic [31:0] b,
                       input logic [4:0] s);
    aluctrl  = op;
    src_a    = a;
    src_b    = b;
    sa       = s;
    in_valid = 1'b1;
  endtask

  // accept a divide, then count stalled cycles until out_valid
  task automatic run_div(input logic [4:0] op,
                         input logic [31:0] a,
                         input logic [31:0] b,
                         output int c,
                         output int bz);
    issue(op, a, b, 5'd0);
    tick();
    in_valid = 1'b0;
    c  = 1;
    bz = 0;
    while (out_valid !== 1'b1 && c < 60) begin
      if (in_ready === 1'b0) bz++;
      tick();
      c++;
    end
  endtask

  initial begin
    total    = 0;
    passed   = 0;
    resetn   = 1'b0;
    flush    = 1'b0;
    in_valid = 1'b0;
    aluctrl  = '0;
    src_a    = '0;
    src_b    = '0;
    sa       = '0;
    tick();
    tick();
    chk("rst_ready", 32'(in_ready), 32'd1);
    chk("rst_ovalid", 32'(out_valid), 32'd0);
    chk("rst_result", result, 32'h0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_zero", 32'(zero), 32'd0);
    chk("rst_hi", hi, 32'h0);
    chk("rst_lo", lo, 32'h0);
    resetn = 1'b1;
    tick();

    // T1 ADD overflow
    issue(OP_ADD, 32'h7fffffff, 32'h1, 5'd0);
    tick();
    in_valid = 1'b0;
    chk("t1_ovalid", 32'(out_valid), 32'd1);
    chk("t1_result", result, 32'h80000000);
    chk("t1_ovf", 32'(overflow), 32'd1);
    chk("t1_zero", 32'(zero), 32'd0);
    tick();
    chk("t1_pulse", 32'(out_valid), 32'd0);

    // T2 SRA then SRAV back-to-back
    issue(OP_SRA, 32'h0, 32'hf0000000, 5'd4);
    tick();
    chk("t2_sra_v", 32'(out_valid), 32'd1);
    chk("t2_sra", result, 32'hff000000);
    issue(OP_SRAV, 32'h8, 32'h80000000, 5'd0);
    tick();
    in_valid = 1'b0;
    chk("t2_srav_v", 32'(out_valid), 32'd1);
    chk("t2_srav", result, 32'hff800000);

    // other single-cycle ops
    issue(OP_SUB, 32'h5, 32'h5, 5'd0);
    tick();
    chk("sub_res", result, 32'h0);
    chk("sub_zero", 32'(zero), 32'd1);
    issue(OP_SUB, 32'h80000000, 32'h1, 5'd0);
    tick();
    chk("subo_res", result, 32'h7fffffff);
    chk("subo_ovf", 32'(overflow), 32'd1);
    issue(OP_SLT, 32'hffffffff, 32'h1, 5'd0);
    tick();
    chk("slt_res", result, 32'h1);
    chk("slt_ovf", 32'(overflow), 32'd0);
    issue(OP_NOR, 32'h0, 32'h0f0f0000, 5'd0);
    tick();
    chk("nor_res", result, 32'hf0f0ffff);
    issue(OP_BAD, 32'h1234, 32'h5678, 5'd0);
    tick();
    in_valid = 1'b0;
    chk("bad_v", 32'(out_valid), 32'd1);
    chk("bad_res", result, 32'h0);
    chk("bad_ovf", 32'(overflow), 32'd0);
    chk("bad_hi", hi, 32'h0);

    // T5 multiply
    issue(OP_MULT, 32'hffffffff, 32'hffffffff, 5'd0);
    tick();
    chk("mult_v", 32'(out_valid), 32'd1);
    chk("mult_hi", hi, 32'h0);
    chk("mult_lo", lo, 32'h1);
    chk("mult_res", result, 32'h1);
    issue(OP_MULTU, 32'hffffffff, 32'hffffffff, 5'd0);
    tick();
    in_valid = 1'b0;
    chk("multu_hi", hi, 32'hfffffffe);
    chk("multu_lo", lo, 32'h00000001);

    // T3 signed divide latency and result
    run_div(OP_DIV, 32'hfffffff9, 32'h2, cyc, busy);
    chk("t3_lat", 32'(cyc), 32'd34);
    chk("t3_busy", 32'(busy), 32'd33);
    chk("t3_lo", lo, 32'hfffffffd);
    chk("t3_hi", hi, 32'hffffffff);
    chk("t3_res", result, 32'hfffffffd);
    chk("t3_ready", 32'(in_ready), 32'd1);
    tick();
    chk("t3_pulse", 32'(out_valid), 32'd0);

    // T4 divide by zero and the signed overflow case
    run_div(OP_DIVU, 32'h5, 32'h0, cyc, busy);
    chk("t4z_lat", 32'(cyc), 32'd34);
    chk("t4z_lo", lo, 32'hffffffff);
    chk("t4z_hi", hi, 32'h5);
    run_div(OP_DIV, 32'h80000000, 32'hffffffff, cyc, busy);
    chk("t4o_lo", lo, 32'h80000000);
    chk("t4o_hi", hi, 32'h0);
    run_div(OP_DIV, 32'h7, 32'hfffffffe, cyc, busy);
    chk("divn_lo", lo, 32'hfffffffd);
    chk("divn_hi", hi, 32'h1);
    run_div(OP_DIVU, 32'hffffffff, 32'ha, cyc, busy);
    chk("divu_lo", lo, 32'h19999999);
    chk("divu_hi", hi, 32'h5);

    // in_valid with flush in IDLE is not accepted
    issue(OP_ADD, 32'h1, 32'h1, 5'd0);
    flush = 1'b1;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("fl_noacc", 32'(out_valid), 32'd0);

    // T6a flush at divide cycle 10
    issue(OP_DIV, 32'd100, 32'd7, 5'd0);
    tick();
    in_valid = 1'b0;
    chk("t6_stall", 32'(in_ready), 32'd0);
    for (int i = 1; i < 10; i++) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("t6f_ready", 32'(in_ready), 32'd1);
    chk("t6f_ovalid", 32'(out_valid), 32'd0);
    chk("t6f_hi", hi, 32'h5);
    chk("t6f_lo", lo, 32'h19999999);
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid === 1'b1) pulses++;
      tick();
    end
    chk("t6f_nopulse", 32'(pulses), 32'd0);

    // T6b reset mid-divide
    issue(OP_DIV, 32'd100, 32'd7, 5'd0);
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    chk("t6r_ready", 32'(in_ready), 32'd1);
    chk("t6r_ovalid", 32'(out_valid), 32'd0);
    chk("t6r_hi", hi, 32'h0);
    chk("t6r_lo", lo, 32'h0);
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid === 1'b1) pulses++;
      tick();
    end
    chk("t6r_nopulse", 32'(pulses), 32'd0);

    // unit works again after the abort
    issue(OP_ADD, 32'h2, 32'h3, 5'd0);
    tick();
    in_valid = 1'b0;
    chk("post_res", result, 32'h5);
    chk("post_v", 32'(out_valid), 32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
